// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW reference streaming path: FSM encoding and stream field widths.
package dtw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } dtw_state_e;

  // Sideband carried next to each sample in the output buffer.
  localparam int STREAM_LAST_W = 1;

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dtw_stream_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and flush; holds (last, data) stream entries.
module dtw_stream_fifo
  import dtw_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = fifo_cnt_w(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk_in) begin
    if (rst_in || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dtw_core_ref_streamer.sv
// Walks the loaded reference memory once per start and streams samples over valid/ready.
// Stream handshake: a beat transfers when m_valid_out & m_ready_in at a rising clk_in;
// while m_valid_out is high and not accepted, m_data_out/m_last_out hold steady.
module dtw_core_ref_streamer
  import dtw_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int ADDR_WIDTH       = 32,
  parameter int REFMEM_PTR_WIDTH = 20,
  parameter int BUF_DEPTH        = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        start_in,
  input  logic                        abort_in,
  input  logic [ADDR_WIDTH-1:0]       ref_len_in,
  input  logic                        ref_load_done_in,
  output logic                        busy_out,
  output logic                        done_out,
  output logic                        err_out,
  output logic [REFMEM_PTR_WIDTH-1:0] ref_addr_out,
  input  logic [DATA_WIDTH-1:0]       ref_data_in,
  output logic [DATA_WIDTH-1:0]       m_data_out,
  output logic                        m_valid_out,
  input  logic                        m_ready_in,
  output logic                        m_last_out,
  output logic [1:0]                  dbg_state
);

  localparam int CNT_W   = fifo_cnt_w(BUF_DEPTH);
  localparam int ENTRY_W = DATA_WIDTH + STREAM_LAST_W;

  dtw_state_e                  state_q, state_d;
  logic [REFMEM_PTR_WIDTH-1:0] addr_q;
  logic [REFMEM_PTR_WIDTH-1:0] len_q;
  logic [REFMEM_PTR_WIDTH-1:0] len_in;
  logic                        inflight_q;
  logic                        inflight_last_q;
  logic                        err_q;
  logic                        err_d;
  logic                        issue;
  logic                        flush;
  logic                        at_last_addr;
  logic                        credit_ok;
  logic                        fifo_empty;
  logic [CNT_W-1:0]            occ;
  logic [ENTRY_W-1:0]          fifo_dout;
  logic                        unused_len_hi;

  assign len_in        = ref_len_in[REFMEM_PTR_WIDTH-1:0];
  assign unused_len_hi = ^ref_len_in[ADDR_WIDTH-1:REFMEM_PTR_WIDTH];
  assign at_last_addr  = (addr_q == len_q - REFMEM_PTR_WIDTH'(1));
  // Credits count the read still on its way back; a same-cycle pop is deliberately ignored.
  assign credit_ok     = (occ + CNT_W'(inflight_q)) < CNT_W'(BUF_DEPTH);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    err_d   = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          if (ref_load_done_in && (len_in != '0)) state_d = ST_STREAM;
          else                                    err_d   = 1'b1;
        end
      end
      ST_STREAM: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (at_last_addr) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !inflight_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_in) begin
      state_d = ST_IDLE;
      issue   = 1'b0;
      err_d   = 1'b0;
      flush   = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      err_q           <= err_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && at_last_addr;
      if (state_q == ST_IDLE && state_d == ST_STREAM) len_q <= len_in;
      // The final address is held through DRAIN/DONE rather than stepping past the reference.
      if (state_d == ST_IDLE)           addr_q <= '0;
      else if (issue && !at_last_addr)  addr_q <= addr_q + REFMEM_PTR_WIDTH'(1);
    end
  end

  dtw_stream_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .flush  (flush),
    .push   (inflight_q),
    .din    ({inflight_last_q, ref_data_in}),
    .pop    (m_valid_out && m_ready_in),
    .dout   (fifo_dout),
    .empty  (fifo_empty),
    .count  (occ)
  );

  assign m_valid_out  = !fifo_empty;
  assign m_data_out   = fifo_empty ? '0 : fifo_dout[DATA_WIDTH-1:0];
  assign m_last_out   = fifo_empty ? 1'b0 : fifo_dout[DATA_WIDTH];
  assign busy_out     = (state_q != ST_IDLE);
  assign done_out     = (state_q == ST_DONE);
  assign err_out      = err_q;
  assign ref_addr_out = addr_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dtw_core_ref_streamer.sv
// Directed and randomized bench for dtw_core_ref_streamer with a behavioural reference-memory model.
module tb_dtw_core_ref_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] ref_len;
  logic        load_done;
  logic        busy;
  logic        done;
  logic        err;
  logic [19:0] ref_addr;
  logic [15:0] ref_data;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [1:0]  dbg_state;

  logic [15:0] ref_mem [0:63];
  logic [16:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  // Reference memory: one-cycle registered read.
  always @(posedge clk) ref_data <= ref_mem[ref_addr[5:0]];

  dtw_core_ref_streamer dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .start_in         (start),
    .abort_in         (abort),
    .ref_len_in       (ref_len),
    .ref_load_done_in (load_done),
    .busy_out         (busy),
    .done_out         (done),
    .err_out          (err),
    .ref_addr_out     (ref_addr),
    .ref_data_in      (ref_data),
    .m_data_out       (m_data),
    .m_valid_out      (m_valid),
    .m_ready_in       (m_ready),
    .m_last_out       (m_last),
    .dbg_state        (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_addr"}, ref_addr, 0);
    check({tag, "_valid"}, m_valid, 0);
    check({tag, "_data"}, m_data, 0);
    check({tag, "_last"}, m_last, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // mode 0: ready held high, 1: ready toggles, 2: random ready and load_done dropped mid-pass
  task automatic run_pass(input int len, input int mode);
    int          cyc, first_v, last_hs, dones;
    logic        pv, pr;
    logic [16:0] prev, exp;
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), ref_mem[i]});
    m_ready = 1'b1;
    ref_len = len;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (mode == 2) load_done = 1'b0;
    cyc = 1; first_v = -1; last_hs = -1; dones = 0; pv = 0; pr = 0; prev = '0;
    @(negedge clk);
    check("addr0", ref_addr, 0);
    check("busy_start", busy, 1);
    while (cyc < 400 && dones == 0) begin
      if (pv && !pr) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", {m_last, m_data}, prev);
      end
      if (m_valid && first_v < 0) first_v = cyc;
      if (dbg_state == 2'd2) check("drain_addr", ref_addr, len - 1);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("extra_beat", exp_q.size(), 1);
        else begin
          exp = exp_q.pop_front();
          check("beat", {m_last, m_data}, exp);
        end
        last_hs = cyc;
      end
      if (done) begin
        dones++;
        check("done_gap", cyc - last_hs, 2);
      end
      pv = m_valid; pr = m_ready; prev = {m_last, m_data};
      @(posedge clk); #1;
      if (mode == 1) m_ready = ~m_ready;
      else if (mode == 2) m_ready = 1'($urandom_range(0, 1));
      cyc++;
      @(negedge clk);
    end
    check("done_count", dones, 1);
    check("beats_left", exp_q.size(), 0);
    check("busy_after", busy, 0);
    check("valid_after", m_valid, 0);
    check("state_after", dbg_state, 0);
    if (mode == 0) begin
      check("first_valid_cyc", first_v, 3);
      check("last_hs_cyc", last_hs, len + 2);
    end
    load_done = 1'b1;
    m_ready   = 1'b1;
  endtask

  task automatic start_and_accept(input int len, input int n);
    int cyc, hs;
    m_ready = 1'b1;
    ref_len = len;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; hs = 0;
    while (cyc < 100 && hs < n) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        check("pre_beat", m_data, ref_mem[hs]);
        hs++;
      end
      cyc++;
      if (hs < n) begin @(posedge clk); #1; end
    end
    check("partial_hs", hs, n);
  endtask

  task automatic try_reject(input logic ld, input logic [31:0] len, input string tag);
    load_done = ld;
    ref_len   = len;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({tag, "_err"}, err, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, m_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_err_clr"}, err, 0);
    check({tag, "_busy2"}, busy, 0);
    load_done = 1'b1;
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; abort = 1'b0; ref_len = '0; load_done = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'h0100 + 16'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0; load_done = 1'b1;
    @(negedge clk);

    run_pass(8, 0);
    run_pass(8, 1);
    run_pass(1, 0);

    try_reject(1'b0, 32'd8, "rej_noload");
    try_reject(1'b1, 32'd0, "rej_len0");
    try_reject(1'b1, 32'h0010_0000, "rej_len_wrap");

    // Abort while the consumer is stalled.
    start_and_accept(16, 5);
    @(posedge clk); #1;
    m_ready = 1'b0; abort = 1'b1; start = 1'b1;
    @(negedge clk);
    check("abort_pre_valid", m_valid, 1);
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    check("abort_valid", m_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_state", dbg_state, 0);
    check("abort_err", err, 0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    run_pass(16, 0);

    // Synchronous reset mid-pass.
    start_and_accept(16, 3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    run_pass(16, 0);

    // Random contents, lengths and backpressure.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 64; i++) ref_mem[i] = 16'($urandom);
      run_pass($urandom_range(1, 20), (k == 4) ? 0 : 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
